alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 44 ++++
 rtl/alu_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, grant and result signals shared by two ALU
// requesters, the result consumer and the alu_arbiter block.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic [2:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_ready;

   logic             req1_valid;
   logic [2:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_ready;

   logic             res_valid;
   logic             res_id;
   logic [WIDTH-1:0] res_data;
   logic             res_ready;

   logic             busy;

   // requester/consumer side
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_id, res_data,
      input  busy
   );

   // arbiter side
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_id, res_data,
      output busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter between two requesters sharing one ALU.
// Single-cycle ops complete with latency 1; MULT runs a 32-step shift-add
// sequence. One operation is in flight at a time; the result is held until
// the consumer handshakes it.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_MULT = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             ptr_r;          // 0 favours requester 0 on a tie
   logic [4:0]       cnt_r;          // multiplier bit being processed
   logic [WIDTH-1:0] mcand_r;        // multiplicand, shifted left each step
   logic [WIDTH-1:0] mplier_r;       // multiplier, shifted right each step
   logic [WIDTH-1:0] acc_r;          // running low half of the product
   logic             id_r;           // requester owning the operation
   logic             res_id_r;
   logic [WIDTH-1:0] res_data_r;

   logic             gnt0_s;
   logic             gnt1_s;
   logic             accept_s;
   logic             gnt_id_s;
   logic [2:0]       sel_op_s;
   logic [WIDTH-1:0] sel_a_s;
   logic [WIDTH-1:0] sel_b_s;
   logic [WIDTH-1:0] mult_sum_s;

   // Single-cycle ALU; MULT is handled by the sequential shift-add path.
   function automatic logic [WIDTH-1:0] alu_f(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_ADD:  r = a + b;
         OP_XOR:  r = a ^ b;
         OP_NOR:  r = ~(a | b);
         OP_SUB:  r = a - b;
         OP_SLT:  r = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                                : {WIDTH{1'b0}};
         default: r = {WIDTH{1'b0}};
      endcase
      return r;
   endfunction

   // Grant: only in IDLE and out of reset; a tie goes to the favoured requester.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if ((state_r == ST_IDLE) && !reset) begin
         if (bus.req0_valid && bus.req1_valid) begin
            gnt0_s = ~ptr_r;
            gnt1_s = ptr_r;
         end else begin
            gnt0_s = bus.req0_valid;
            gnt1_s = bus.req1_valid;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Select the granted requester's operation for capture.
   always_comb begin
      accept_s = gnt0_s | gnt1_s;
      gnt_id_s = gnt1_s;
      if (gnt1_s) begin
         sel_op_s = bus.req1_op;
         sel_a_s  = bus.req1_a;
         sel_b_s  = bus.req1_b;
      end else begin
         sel_op_s = bus.req0_op;
         sel_a_s  = bus.req0_a;
         sel_b_s  = bus.req0_b;
      end
      mult_sum_s = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
   end

   // State register; reset overrides any operation in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = (sel_op_s == OP_MULT) ? ST_EXEC : ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_r == 5'd31) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_EXEC;
            end
         end
         ST_DONE: begin
            if (bus.res_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Outputs: grants, status and the held result.
   always_comb begin
      bus.req0_ready = gnt0_s;
      bus.req1_ready = gnt1_s;
      bus.busy       = (state_r != ST_IDLE);
      bus.res_valid  = (state_r == ST_DONE);
      bus.res_id     = res_id_r;
      bus.res_data   = res_data_r;
   end

   // Datapath: capture on accept, shift-add in EXEC, result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r      <= 1'b0;
         cnt_r      <= 5'd0;
         mcand_r    <= {WIDTH{1'b0}};
         mplier_r   <= {WIDTH{1'b0}};
         acc_r      <= {WIDTH{1'b0}};
         id_r       <= 1'b0;
         res_id_r   <= 1'b0;
         res_data_r <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         ptr_r    <= ~gnt_id_s;
         cnt_r    <= 5'd0;
         mcand_r  <= sel_a_s;
         mplier_r <= sel_b_s;
         acc_r    <= {WIDTH{1'b0}};
         id_r     <= gnt_id_s;
         if (sel_op_s != OP_MULT) begin
            res_id_r   <= gnt_id_s;
            res_data_r <= alu_f(sel_op_s, sel_a_s, sel_b_s);
         end else begin
            res_id_r   <= res_id_r;
            res_data_r <= res_data_r;
         end
      end else if (state_r == ST_EXEC) begin
         cnt_r    <= cnt_r + 5'd1;
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         acc_r    <= mult_sum_s;
         if (cnt_r == 5'd31) begin
            res_id_r   <= id_r;
            res_data_r <= mult_sum_s;
         end else begin
            res_id_r   <= res_id_r;
            res_data_r <= res_data_r;
         end
      end else begin
         ptr_r      <= ptr_r;
         cnt_r      <= cnt_r;
         res_id_r   <= res_id_r;
         res_data_r <= res_data_r;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed stimulus against a transaction-level
// reference model; expected results are queued at accept time and checked by
// an independent monitor when the DUT hands a result over.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic reset;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [32:0] exp_q[$];     // {id, data}

   // transaction-level model state
   bit m_pending;             // an operation is in flight or awaiting handshake
   bit m_ptr;                 // requester favoured on a tie
   int m_rdy_cyc;             // cycle in which the result becomes visible
   int cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint unsigned p;
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
         3'd3: return a ^ b;
         3'd4: return ~(a | b);
         3'd5: begin
            p = longint'(a) * longint'(b);
            return p[31:0];
         end
         3'd6: return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
         3'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // One clock cycle: drive, check handshake/status against the model, advance model.
   task automatic step(input bit v0, input logic [2:0] o0, input logic [31:0] a0,
                       input logic [31:0] b0, input bit v1, input logic [2:0] o1,
                       input logic [31:0] a1, input logic [31:0] b1, input bit rr,
                       input bit rst);
      bit         idle, g, e_r0, e_r1, e_rv;
      logic [2:0] op;
      @(posedge clk);
      #1;
      reset = rst;
      bus.req0_valid = v0; bus.req0_op = o0; bus.req0_a = a0; bus.req0_b = b0;
      bus.req1_valid = v1; bus.req1_op = o1; bus.req1_a = a1; bus.req1_b = b1;
      bus.res_ready  = rr;
      #1;
      idle = !m_pending && !rst;
      g    = (v0 && v1) ? m_ptr : v1;
      e_r0 = idle && (v0 || v1) && !g;
      e_r1 = idle && (v0 || v1) && g;
      e_rv = m_pending && (cyc >= m_rdy_cyc);
      chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
      chk("res_valid", 32'(bus.res_valid), 32'(e_rv));
      chk("busy", 32'(bus.busy), 32'(m_pending));
      if (rst) begin
         m_pending = 1'b0;
         m_ptr     = 1'b0;
         exp_q.delete();
      end else if (e_rv && rr) begin
         m_pending = 1'b0;
      end else if (idle && (v0 || v1)) begin
         op        = g ? o1 : o0;
         m_pending = 1'b1;
         m_rdy_cyc = cyc + ((op == 3'd5) ? 33 : 1);
         exp_q.push_back({g, g ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0)});
         m_ptr     = !g;
      end
      cyc++;
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [2:0] rnd_op();
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if (o == 3'd5 && $urandom_range(0, 1) == 0) o = 3'($urandom_range(0, 4));
      return o;
   endfunction

   task automatic nop(input int n, input bit rr);
      for (int i = 0; i < n; i++)
         step(1'b0, rnd_op(), rnd_val(), rnd_val(), 1'b0, rnd_op(), rnd_val(), rnd_val(), rr, 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic r0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit rr);
      step(1'b1, op, a, b, 1'b0, 3'd0, 32'd0, 32'd0, rr, 1'b0);
   endtask

   task automatic r1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit rr);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, op, a, b, rr, 1'b0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_res_id", 32'(bus.res_id), 32'd0);
      chk("rst_res_data", bus.res_data, 32'd0);
   endtask

   // Monitor: pops and compares on each result handshake, checks hold stability.
   initial begin : monitor
      bit          hold;
      logic        hid;
      logic [31:0] hdata;
      logic [32:0] e;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (hold && bus.res_valid) begin
            chk("hold_res_id", 32'(bus.res_id), 32'(hid));
            chk("hold_res_data", bus.res_data, hdata);
         end
         if (bus.res_valid && bus.res_ready && !reset) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: got id=%0d data=%h expected none", bus.res_id, bus.res_data);
            end else begin
               e = exp_q.pop_front();
               chk("res_id", 32'(bus.res_id), 32'(e[32]));
               chk("res_data", bus.res_data, e[31:0]);
            end
         end
         hold  = bus.res_valid && !bus.res_ready && !reset;
         hid   = bus.res_id;
         hdata = bus.res_data;
      end
   end

   initial begin : driver
      reset = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
      bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
      bus.res_ready  = 1'b0;
      m_pending = 1'b0; m_ptr = 1'b0; m_rdy_cyc = 0; cyc = 0;

      do_reset(2);
      nop(1, 1'b1);
      chk_reset_vals();

      // OR latency 1
      r0(3'd1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
      nop(2, 1'b1);

      // round robin: both valid right after reset
      do_reset(1);
      for (int i = 0; i < 6; i++)
         step(1'b1, 3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b0);
      nop(2, 1'b1);

      // MULT from requester 1
      r1(3'd5, 32'h0000_1234, 32'h0000_0010, 1'b1);
      nop(36, 1'b1);
      r1(3'd5, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      nop(36, 1'b1);

      // arithmetic corners
      r0(3'd6, 32'h0000_0000, 32'h0000_0001, 1'b1); nop(2, 1'b1);
      r0(3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1); nop(2, 1'b1);
      r1(3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1); nop(2, 1'b1);
      r1(3'd7, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1); nop(2, 1'b1);
      r0(3'd4, 32'h0F0F_0000, 32'h00F0_00FF, 1'b1); nop(2, 1'b1);

      // result held under back-pressure with a new request waiting
      r0(3'd1, 32'h1234_0000, 32'h0000_5678, 1'b0);
      for (int i = 0; i < 6; i++) r0(3'd2, 32'h1111_1111, 32'h2222_2222, 1'b0);
      r0(3'd2, 32'h1111_1111, 32'h2222_2222, 1'b1);
      r0(3'd2, 32'h1111_1111, 32'h2222_2222, 1'b1);
      nop(2, 1'b1);

      // reset during the 10th EXEC cycle of a MULT
      r1(3'd5, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
      nop(9, 1'b1);
      do_reset(1);
      nop(1, 1'b1);
      chk_reset_vals();
      r0(3'd1, 32'hA0A0_0000, 32'h0000_0505, 1'b1);
      nop(2, 1'b1);

      // randomized traffic
      for (int i = 0; i < 500; i++)
         step(1'($urandom_range(0, 1)), rnd_op(), rnd_val(), rnd_val(),
              1'($urandom_range(0, 1)), rnd_op(), rnd_val(), rnd_val(),
              1'($urandom_range(0, 3) != 0), 1'b0);

      nop(40, 1'b1);
      @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
